snoop_bus_arbiter: RTL and testbench
====================================

# snoop_bus_arbiter

Round-robin arbiter and transaction sequencer for the shared snoop bus (`Address_Com` / `Data_Bus_Com`) used by the four per-core L1 cache controllers.
- Grants the bus to one requesting cache at a time.
- Drives the snoop phase and collects snoop acknowledgements from the other three caches.
- Holds the grant until the owner signals completion.
- Recovers from a hung transaction with a timeout.

One instance serves the instruction-cache bus and one serves the data-cache bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles one ownership (SNOOP + DATA) may last; legal range 2..255.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Bus_req`  in  4  per-core bus request, level; bit i = core i.
- `Snoop_ack`  in  4  per-core snoop-complete pulse/level; bit i = core i.
- `Bus_done`  in  4  per-core transaction-complete pulse; bit i = core i.
- `Bus_grant`  out  4  one-hot (or zero) ownership indication.
- `Owner_id`  out  2  binary index of current owner; 0 when idle.
- `Snoop_req`  out  1  high while the snoop phase is active.
- `All_snooped`  out  1  single-cycle pulse: all non-owner caches have acked.
- `Bus_busy`  out  1  high in SNOOP or DATA.
- `Timeout_err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: bus free; arbitrate.
  - SNOOP: owner granted; collecting acks.
  - DATA: owner transfers; waiting for `Bus_done[owner]`.
- Arbitration, IDLE only:
  - Round-robin starting at pointer `rr_ptr` (2 bits, reset 0).
  - Winner = first i in order `rr_ptr`, `rr_ptr`+1, … (mod 4) with `Bus_req[i]`=1.
  - No request: stay in IDLE.
- IDLE→SNOOP on a winner: latch owner, set `Bus_grant`=onehot(owner), `Owner_id`=owner, clear `ack_mask`, clear timeout counter.
- SNOOP:
  - `Snoop_req`=1.
  - `ack_mask` |= `Snoop_ack` masked to non-owner bits; the owner's own ack is ignored.
  - When (`ack_mask` | masked `Snoop_ack`) covers all three non-owner bits, go to DATA on the next edge. This includes acks arriving in the first SNOOP cycle.
- DATA:
  - `Snoop_req`=0.
  - `Bus_done[owner]`=1 → IDLE on the next edge; `Bus_done` on non-owner bits is ignored.
- Abort: the owner deasserting `Bus_req` in SNOOP or DATA is treated as `Bus_done`; go to IDLE, no error.
- Leaving SNOOP/DATA for any reason:
  - `rr_ptr` ← (owner+1) mod 4.
  - `Bus_grant` ← 0, `Owner_id` ← 0.
- Timeout:
  - An 8-bit counter increments each cycle in SNOOP/DATA.
  - If it equals `TIMEOUT_CYCLES`-1 and completion did not occur that cycle: force IDLE, set `Timeout_err`=1, advance `rr_ptr` as normal.
- Simultaneous completion and timeout in the same cycle: completion wins; `Timeout_err` is not set.
- `Bus_busy` = state≠IDLE, registered.

## Timing
- Reset values: `Bus_grant`=0000, `Owner_id`=0, `Snoop_req`=0, `All_snooped`=0, `Bus_busy`=0, `Timeout_err`=0. Internal reset values: state=IDLE, `rr_ptr`=0, `ack_mask`=0, counter=0.
- `rst` mid-transaction returns to the reset values on the next edge regardless of state; the grant is dropped with no completion required.
- All outputs are registered.
- Request sampled at edge N with bus idle → `Bus_grant`, `Snoop_req` and `Bus_busy` high from cycle N+1.
- Snoop completion condition true at edge M → `All_snooped`=1 for exactly cycle M+1 (first DATA cycle); `Snoop_req` low from M+1.
- `Bus_done[owner]` sampled at edge K → `Bus_grant`=0 from K+1 (IDLE cycle). Next grant earliest at K+2: exactly one dead cycle between owners.
- Minimum ownership: 2 cycles (1 SNOOP + 1 DATA).
- `Bus_req` of a non-owner during SNOOP/DATA is held pending; the requester must keep it high until granted.

## Test plan
- Reset then `Bus_req`=0100 at cycle 3 → `Bus_grant`=0100 and `Owner_id`=2 at cycle 4; `Snoop_ack`=1011 at cycle 5 → `All_snooped` pulse at cycle 6; `Bus_done`=0100 at cycle 7 → `Bus_grant`=0000 at cycle 8.
- `Bus_req`=1111 held, each owner acks and completes in 2 cycles → grant order core 0,1,2,3,0 with one idle cycle between owners.
- Acks arrive staggered (core1 at cycle t, core3 at t+2, core2 at t+4; owner core0) → `All_snooped` at t+5 only; owner's own ack at t+1 has no effect.
- Owner core3 never asserts `Bus_done`, `TIMEOUT_CYCLES`=8 → grant drops 8 cycles after grant; `Timeout_err`=1 and stays set; next grant goes to core0.
- `Bus_done[owner]` in the same cycle the counter reaches 7 → normal release, `Timeout_err` stays 0.
- `rst` pulsed during DATA with `Bus_req`=0011 → all outputs 0 next cycle; after `rst` falls, core0 is granted (pointer reset).

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for a four-core shared snoop bus.
// Each ownership runs SNOOP (collect peer acks) then DATA (await owner's Bus_done), bounded by a timeout.
module snoop_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Bus_req,
    input  logic [3:0] Snoop_ack,
    input  logic [3:0] Bus_done,
    output logic [3:0] Bus_grant,
    output logic [1:0] Owner_id,
    output logic       Snoop_req,
    output logic       All_snooped,
    output logic       Bus_busy,
    output logic       Timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        DATA
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [1:0] owner;
    logic [1:0] rr_ptr;
    logic [3:0] ack_mask;
    logic [7:0] tmo_cnt;

    logic [3:0] owner_bit;
    logic [3:0] peer_mask;
    logic [3:0] acks_seen;
    logic       snooped;
    logic       finished;
    logic       expired;
    logic       win_valid;
    logic [1:0] win_id;

    always_comb begin
        owner_bit = 4'b0001 << owner;
        peer_mask = ~owner_bit;
        acks_seen = ack_mask | (Snoop_ack & peer_mask);
        snooped   = (acks_seen & peer_mask) == peer_mask;
        // An owner dropping its request mid-transaction is an abort, handled like Bus_done.
        finished  = ~Bus_req[owner] | ((state == DATA) & Bus_done[owner]);
        expired   = (tmo_cnt == TMO_LAST);
        win_valid = 1'b0;
        win_id    = rr_ptr;
        // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
        for (int i = 3; i >= 0; i--) begin
            if (Bus_req[rr_ptr + 2'(i)]) begin
                win_valid = 1'b1;
                win_id    = rr_ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 2'd0;
            rr_ptr      <= 2'd0;
            ack_mask    <= 4'b0000;
            tmo_cnt     <= 8'd0;
            Bus_grant   <= 4'b0000;
            Owner_id    <= 2'd0;
            Snoop_req   <= 1'b0;
            All_snooped <= 1'b0;
            Bus_busy    <= 1'b0;
            Timeout_err <= 1'b0;
        end else begin
            All_snooped <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= SNOOP;
                        owner     <= win_id;
                        Bus_grant <= 4'b0001 << win_id;
                        Owner_id  <= win_id;
                        Snoop_req <= 1'b1;
                        Bus_busy  <= 1'b1;
                        ack_mask  <= 4'b0000;
                        tmo_cnt   <= 8'd0;
                    end
                end
                SNOOP, DATA: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // Completion outranks timeout; timeout outranks the move into DATA.
                    if (finished || expired) begin
                        state     <= IDLE;
                        rr_ptr    <= owner + 2'd1;
                        Bus_grant <= 4'b0000;
                        Owner_id  <= 2'd0;
                        Snoop_req <= 1'b0;
                        Bus_busy  <= 1'b0;
                        if (!finished) begin
                            Timeout_err <= 1'b1;
                        end
                    end else if (state == SNOOP) begin
                        ack_mask <= acks_seen;
                        if (snooped) begin
                            state       <= DATA;
                            Snoop_req   <= 1'b0;
                            All_snooped <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of ownership.
module tb_snoop_bus_arbiter;

    localparam int T = 8;

    logic       clk;
    logic       rst;
    logic [3:0] Bus_req;
    logic [3:0] Snoop_ack;
    logic [3:0] Bus_done;
    logic [3:0] Bus_grant;
    logic [1:0] Owner_id;
    logic       Snoop_req;
    logic       All_snooped;
    logic       Bus_busy;
    logic       Timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: who owns the bus (-1 = nobody), how long, which peers have acked.
    int m_owner;
    int m_age;
    int m_ptr;
    bit m_data;
    bit m_err;
    bit m_pulse;
    bit m_got[4];

    snoop_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .Bus_req    (Bus_req),
        .Snoop_ack  (Snoop_ack),
        .Bus_done   (Bus_done),
        .Bus_grant  (Bus_grant),
        .Owner_id   (Owner_id),
        .Snoop_req  (Snoop_req),
        .All_snooped(All_snooped),
        .Bus_busy   (Bus_busy),
        .Timeout_err(Timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic modelStep(input bit r, input logic [3:0] req, input logic [3:0] ack,
                             input logic [3:0] done);
        bit fin;
        bit found;
        int got_n;
        m_pulse = 1'b0;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_err   = 1'b0;
            m_data  = 1'b0;
            m_age   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_data = 1'b0;
                m_age  = 0;
                for (int j = 0; j < 4; j++) m_got[j] = 1'b0;
            end
        end else begin
            fin = !req[m_owner] || (m_data && done[m_owner]);
            if (fin || m_age == T - 1) begin
                if (!fin) m_err = 1'b1;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_age++;
                if (!m_data) begin
                    got_n = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (j != m_owner && ack[j]) m_got[j] = 1'b1;
                        if (j != m_owner && m_got[j]) got_n++;
                    end
                    if (got_n == 3) begin
                        m_data  = 1'b1;
                        m_pulse = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [3:0] e_grant;
        logic [1:0] e_id;
        e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e_id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        compare("Bus_grant",   Bus_grant,           e_grant);
        compare("Owner_id",    {2'b00, Owner_id},   {2'b00, e_id});
        compare("Snoop_req",   {3'b000, Snoop_req}, {3'b000, (m_owner >= 0) && !m_data});
        compare("All_snooped", {3'b000, All_snooped}, {3'b000, m_pulse});
        compare("Bus_busy",    {3'b000, Bus_busy},  {3'b000, m_owner >= 0});
        compare("Timeout_err", {3'b000, Timeout_err}, {3'b000, m_err});
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] req, input logic [3:0] ack,
                                 input logic [3:0] done);
        @(negedge clk);
        rst       = r;
        Bus_req   = req;
        Snoop_ack = ack;
        Bus_done  = done;
    endtask

    task automatic cycle(input bit r, input logic [3:0] req, input logic [3:0] ack,
                         input logic [3:0] done);
        applyStimulus(r, req, ack, done);
        @(posedge clk);
        modelStep(r, req, ack, done);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] s_req;
        logic [3:0] s_ack;
        logic [3:0] s_done;
        bit         served[4];
        bit         s_rst;
        int         prev;

        rst       = 1'b1;
        Bus_req   = 4'b0000;
        Snoop_ack = 4'b0000;
        Bus_done  = 4'b0000;
        m_owner   = -1;
        m_ptr     = 0;
        m_age     = 0;
        m_data    = 1'b0;
        m_err     = 1'b0;
        m_pulse   = 1'b0;
        for (int j = 0; j < 4; j++) m_got[j] = 1'b0;

        // Basic transaction by core 2
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        compare("reset_grant", Bus_grant, 4'b0000);
        cycle(0, 4'b0000, 4'b0000, 4'b0000);
        cycle(0, 4'b0100, 4'b0000, 4'b0000);
        compare("basic_grant", Bus_grant, 4'b0100);
        compare("basic_owner", {2'b00, Owner_id}, 4'd2);
        compare("basic_sreq",  {3'b000, Snoop_req}, 4'd1);
        cycle(0, 4'b0100, 4'b1011, 4'b0000);
        compare("basic_allsn", {3'b000, All_snooped}, 4'd1);
        compare("basic_sreq_off", {3'b000, Snoop_req}, 4'd0);
        cycle(0, 4'b0100, 4'b0000, 4'b0100);
        compare("basic_release", Bus_grant, 4'b0000);

        // Round robin with all four requesting
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            cycle(0, 4'b1111, 4'b0000, 4'b0000);
            compare("rr_grant", Bus_grant, oh);
            cycle(0, 4'b1111, ~oh, 4'b0000);
            cycle(0, 4'b1111, 4'b0000, oh);
            compare("rr_gap", Bus_grant, 4'b0000);
        end

        // Staggered acks, owner core 0; its own ack is ignored
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        cycle(0, 4'b0001, 4'b0000, 4'b0000);
        cycle(0, 4'b0001, 4'b0010, 4'b0000);
        cycle(0, 4'b0001, 4'b0001, 4'b0000);
        cycle(0, 4'b0001, 4'b1000, 4'b0000);
        compare("stag_early", {3'b000, All_snooped}, 4'd0);
        cycle(0, 4'b0001, 4'b0000, 4'b0000);
        cycle(0, 4'b0001, 4'b0100, 4'b0000);
        compare("stag_pulse", {3'b000, All_snooped}, 4'd1);
        cycle(0, 4'b0001, 4'b0000, 4'b0001);

        // Timeout: core 3 never completes
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        cycle(0, 4'b1000, 4'b0000, 4'b0000);
        compare("tmo_grant", Bus_grant, 4'b1000);
        for (int k = 1; k < T; k++) begin
            cycle(0, 4'b1000, 4'b0000, 4'b0000);
            compare("tmo_hold", Bus_grant, 4'b1000);
        end
        cycle(0, 4'b1000, 4'b0000, 4'b0000);
        compare("tmo_drop", Bus_grant, 4'b0000);
        compare("tmo_err",  {3'b000, Timeout_err}, 4'd1);
        cycle(0, 4'b1001, 4'b0000, 4'b0000);
        compare("tmo_next", Bus_grant, 4'b0001);
        cycle(0, 4'b1001, 4'b1110, 4'b0000);
        cycle(0, 4'b1001, 4'b0000, 4'b0001);
        compare("tmo_sticky", {3'b000, Timeout_err}, 4'd1);

        // Completion on the last allowed cycle wins over timeout
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        cycle(0, 4'b0010, 4'b0000, 4'b0000);
        cycle(0, 4'b0010, 4'b1101, 4'b0000);
        for (int k = 0; k < T - 2; k++) cycle(0, 4'b0010, 4'b0000, 4'b0000);
        compare("edge_hold", Bus_grant, 4'b0010);
        cycle(0, 4'b0010, 4'b0000, 4'b0010);
        compare("edge_release", Bus_grant, 4'b0000);
        compare("edge_noerr", {3'b000, Timeout_err}, 4'd0);

        // Reset during DATA clears the pointer
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        cycle(0, 4'b0011, 4'b0000, 4'b0000);
        cycle(0, 4'b0011, 4'b1110, 4'b0000);
        cycle(0, 4'b0011, 4'b0000, 4'b0001);
        cycle(0, 4'b0011, 4'b0000, 4'b0000);
        compare("rst_pre", Bus_grant, 4'b0010);
        cycle(0, 4'b0011, 4'b1101, 4'b0000);
        cycle(1, 4'b0011, 4'b0000, 4'b0000);
        compare("rst_grant", Bus_grant, 4'b0000);
        compare("rst_busy", {3'b000, Bus_busy}, 4'd0);
        cycle(0, 4'b0011, 4'b0000, 4'b0000);
        compare("rst_after", Bus_grant, 4'b0001);

        // Random traffic; requesters hold until served, owners occasionally abort
        cycle(1, 4'b0000, 4'b0000, 4'b0000);
        s_req = 4'b0000;
        for (int j = 0; j < 4; j++) served[j] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == m_owner) begin
                    if ($urandom_range(39) == 0) s_req[i] = 1'b0;
                end else if (!s_req[i]) begin
                    s_req[i] = ($urandom_range(3) == 0);
                    served[i] = 1'b0;
                end else if (served[i] && $urandom_range(1) == 0) begin
                    s_req[i]  = 1'b0;
                    served[i] = 1'b0;
                end
                s_done[i] = ($urandom_range(4) == 0);
            end
            s_ack = 4'($urandom_range(15));
            s_rst = ($urandom_range(299) == 0);
            prev  = m_owner;
            cycle(s_rst, s_req, s_ack, s_done);
            if (prev >= 0 && m_owner != prev) served[prev] = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
